// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state encoding and width helpers for the sequential FIR
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } fir_state_e;

    // Wide enough that TAPS full-scale products can never wrap.
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    function automatic logic [63:0] round_const(input int shift);
        return (shift > 0) ? (64'd1 << (shift - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shadow/active coefficient banks with deferred commit
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int TAPS = 21,
    parameter int CW   = 16,
    parameter int IW   = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coef_wr,
    input  logic [IW-1:0]        coef_addr,
    input  logic [CW-1:0]        coef_data,
    input  logic                 coef_commit,
    input  logic                 busy_i,
    input  logic                 done_i,
    input  logic [IW-1:0]        rd_idx_i,
    output logic [CW-1:0]        coef_current,
    output logic signed [CW-1:0] rd_coef_o
);

    localparam logic [IW:0] TAPS_W = TAPS[IW:0];

    logic signed [CW-1:0] shadow_q [TAPS];
    logic signed [CW-1:0] shadow_d [TAPS];
    logic signed [CW-1:0] active_q [TAPS];
    logic                 pending_q;
    logic                 pending_d;
    logic                 commit_now;
    logic                 addr_ok;

    assign addr_ok = ({1'b0, coef_addr} < TAPS_W);

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (coef_wr && addr_ok) begin
            shadow_d[coef_addr] = coef_data;
        end
    end

    // A commit seen mid-computation waits for the ROUND->IDLE edge so the
    // active bank stays frozen while a sample is being filtered.
    always_comb begin
        commit_now = (coef_commit && (!busy_i || done_i)) || (pending_q && done_i);
        pending_d  = pending_q;
        if (done_i) begin
            pending_d = 1'b0;
        end else if (coef_commit && busy_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pending_q <= 1'b0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (commit_now) begin
                    active_q[i] <= shadow_d[i];
                end
            end
            pending_q <= pending_d;
        end
    end

    assign coef_current = addr_ok ? shadow_q[coef_addr] : '0;
    assign rd_coef_o    = active_q[rd_idx_i];

endmodule

// File: rtl/fir_seq_param.sv
// rtl/fir_seq_param.sv - sequential single-multiplier FIR with rounding and saturation
module fir_seq_param
    import fir_pkg::*;
#(
    parameter int TAPS  = 21,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 24,
    parameter int SHIFT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DW-1:0]             din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic [OW-1:0]             dout,
    output logic                      dout_valid,
    output logic                      sat,
    input  logic                      coef_wr,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic [CW-1:0]             coef_data,
    input  logic                      coef_commit,
    output logic [CW-1:0]             coef_current
);

    localparam int IW = $clog2(TAPS);
    localparam int AW = acc_width(DW, CW, TAPS);
    localparam int PW = DW + CW;
    localparam int RW = AW + 1;
    localparam int SW = (RW > OW) ? RW : OW;
    localparam logic signed [RW-1:0] RND     = RW'(round_const(SHIFT));
    localparam logic [OW-1:0]        SAT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]        SAT_MIN = {1'b1, {(OW-1){1'b0}}};

    fir_state_e           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic signed [DW-1:0] x_q [TAPS];
    logic signed [AW-1:0] acc_q, acc_d;
    logic [OW-1:0]        res_q, res_d;
    logic                 res_sat_q, res_sat_d;
    logic                 out_pend_q;
    logic [OW-1:0]        dout_q;
    logic                 dout_valid_q;
    logic                 sat_q;

    logic                 accept;
    logic                 busy;
    logic                 done;
    logic                 last_tap;
    logic signed [DW-1:0] x_sel;
    logic signed [CW-1:0] rd_coef;
    logic signed [PW-1:0] prod;
    logic signed [RW-1:0] rsum;
    logic signed [RW-1:0] rshf;
    logic signed [SW-1:0] rext;
    logic [SW-OW:0]       hi;
    logic                 clip;

    fir_coef_bank #(
        .TAPS (TAPS),
        .CW   (CW),
        .IW   (IW)
    ) u_bank (
        .clk          (clk),
        .reset        (reset),
        .coef_wr      (coef_wr),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .coef_commit  (coef_commit),
        .busy_i       (busy),
        .done_i       (done),
        .rd_idx_i     (idx_q),
        .coef_current (coef_current),
        .rd_coef_o    (rd_coef)
    );

    assign accept   = din_valid && din_ready;
    assign last_tap = (idx_q == IW'(TAPS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_MAC;
            ST_MAC:   if (last_tap) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        din_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_ROUND);
    end

    assign x_sel = x_q[idx_q];
    assign prod  = PW'(x_sel) * PW'(rd_coef);

    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        if (accept) begin
            acc_d = '0;
            idx_d = '0;
        end else if (state_q == ST_MAC) begin
            acc_d = acc_q + AW'(prod);
            idx_d = idx_q + 1'b1;
        end
    end

    // Clipping is detected by the bits above the output sign bit disagreeing.
    always_comb begin
        rsum      = RW'(acc_q) + RND;
        rshf      = rsum >>> SHIFT;
        rext      = SW'(rshf);
        hi        = rext[SW-1:OW-1];
        clip      = !((&hi) || !(|hi));
        res_d     = res_q;
        res_sat_d = res_sat_q;
        if (done) begin
            res_d     = clip ? (rext[SW-1] ? SAT_MIN : SAT_MAX) : rext[OW-1:0];
            res_sat_d = clip;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
            acc_q        <= '0;
            idx_q        <= '0;
            res_q        <= '0;
            res_sat_q    <= 1'b0;
            out_pend_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            if (accept) begin
                x_q[0] <= din;
                for (int k = 1; k < TAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
            end
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            res_q        <= res_d;
            res_sat_q    <= res_sat_d;
            out_pend_q   <= done;
            dout_valid_q <= out_pend_q;
            sat_q        <= out_pend_q && res_sat_q;
            if (out_pend_q) begin
                dout_q <= res_q;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_fir_seq_param.sv
// tb/tb_fir_seq_param.sv - randomized self-checking bench for fir_seq_param
module tb_fir_seq_param;

    localparam int TAPS = 21;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int OW   = 24;
    localparam int LAT  = TAPS + 2;
    localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
    localparam longint OMIN = -(64'sd1 <<< (OW - 1));

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          coef_wr = 1'b0;
    logic [4:0]    coef_addr = '0;
    logic [CW-1:0] coef_data = '0;
    logic          coef_commit = 1'b0;

    logic          din_ready0, din_ready1, dout_valid0, dout_valid1, sat0, sat1;
    logic [OW-1:0] dout0, dout1;
    logic [CW-1:0] coef_current0, coef_current1;

    always #5 clk = ~clk;

    fir_seq_param #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(0)) u_dut0 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
        .dout(dout0), .dout_valid(dout_valid0), .sat(sat0), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
        .coef_current(coef_current0)
    );

    fir_seq_param #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(8)) u_dut1 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready1),
        .dout(dout1), .dout_valid(dout_valid1), .sat(sat1), .coef_wr(coef_wr),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
        .coef_current(coef_current1)
    );

    typedef struct {
        int     due;
        longint d0;
        bit     s0;
        longint d1;
        bit     s1;
    } exp_t;

    exp_t   exp_q[$];
    longint log0[$];
    longint log1[$];
    bit     logs1[$];
    int     dut_acc[$];
    int     dv_log[$];
    int     shadow_m [TAPS];
    int     act_m [TAPS];
    int     hist_m [TAPS];
    bit     pend_m = 1'b0;
    int     busy_m = 0;
    int     ecyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint shr_round(input longint acc, input int sh);
        longint v = acc;
        if (sh > 0) v = v + (64'sd1 <<< (sh - 1));
        return v >>> sh;
    endfunction

    function automatic longint clip_o(input longint v);
        return (v > OMAX) ? OMAX : ((v < OMIN) ? OMIN : v);
    endfunction

    always @(posedge clk) ecyc++;

    // Reference: y = sum(x[n-i] * c[i]) over the coefficients active at acceptance,
    // expected on the output TAPS+2 edges after the accepting edge.
    always @(negedge clk) begin
        bit     exp_now;
        exp_t   e;
        exp_t   ne;
        longint acc;
        longint r;
        if (!reset) begin
            exp_q.delete();
            pend_m = 1'b0;
            busy_m = 0;
            for (int i = 0; i < TAPS; i++) begin
                shadow_m[i] = 0;
                act_m[i]    = 0;
                hist_m[i]   = 0;
            end
        end else begin
            if (din_valid && din_ready0) dut_acc.push_back(ecyc + 1);
            if (dout_valid0) dv_log.push_back(ecyc);
            exp_now = (exp_q.size() > 0) && (exp_q[0].due == ecyc);
            if (dout_valid0 || dout_valid1 || exp_now) begin
                chk("dout_valid0", dout_valid0, longint'(exp_now));
                chk("dout_valid1", dout_valid1, longint'(exp_now));
                if (exp_now) begin
                    e = exp_q.pop_front();
                    chk("dout0", $signed(dout0), e.d0);
                    chk("sat0", sat0, longint'(e.s0));
                    chk("dout1", $signed(dout1), e.d1);
                    chk("sat1", sat1, longint'(e.s1));
                    log0.push_back(longint'($signed(dout0)));
                    log1.push_back(longint'($signed(dout1)));
                    logs1.push_back(sat1);
                end
            end
            chk("din_ready0", din_ready0, longint'(busy_m == 0));
            chk("din_ready1", din_ready1, longint'(busy_m == 0));
            if (int'(coef_addr) < TAPS) begin
                chk("coef_current0", $signed(coef_current0), longint'(shadow_m[coef_addr]));
                chk("coef_current1", $signed(coef_current1), longint'(shadow_m[coef_addr]));
            end
            if (coef_wr && int'(coef_addr) < TAPS) shadow_m[coef_addr] = int'($signed(coef_data));
            if (busy_m == 0) begin
                if (coef_commit) act_m = shadow_m;
                if (din_valid) begin
                    for (int k = TAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
                    hist_m[0] = int'($signed(din));
                    acc = 0;
                    for (int i = 0; i < TAPS; i++) acc += longint'(hist_m[i]) * longint'(act_m[i]);
                    r     = shr_round(acc, 0);
                    ne.d0 = clip_o(r);
                    ne.s0 = (r != ne.d0);
                    r     = shr_round(acc, 8);
                    ne.d1 = clip_o(r);
                    ne.s1 = (r != ne.d1);
                    ne.due = ecyc + 1 + LAT;
                    exp_q.push_back(ne);
                    busy_m = TAPS + 1;
                end
            end else begin
                if (busy_m == 1) begin
                    if (pend_m || coef_commit) act_m = shadow_m;
                    pend_m = 1'b0;
                end else if (coef_commit) begin
                    pend_m = 1'b1;
                end
                busy_m--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        coef_wr = 1'b1; coef_addr = 5'(a); coef_data = 16'(d);
        tick();
        coef_wr = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    task automatic send(input int x);
        int n = 0;
        din = 16'(x);
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", din_ready0, 1);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy_m != 0) && n < 500) begin
            tick();
            n++;
        end
        chk("idle_timeout", longint'(n < 500), 1);
    endtask

    task automatic clear_logs();
        log0.delete(); log1.delete(); logs1.delete();
    endtask

    function automatic int rnd_val();
        int v = $urandom;
        if ($urandom_range(0, 1) == 1) return int'($signed(v[15:0]));
        return int'($urandom_range(0, 127)) - 64;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, n_cmp %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int n;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_din_ready", din_ready0, 1);
        chk("rst_dout0", dout0, 0);
        chk("rst_dout1", dout1, 0);
        chk("rst_dout_valid", dout_valid0, 0);
        chk("rst_sat1", sat1, 0);
        tick();

        // impulse response through the SHIFT=0 instance
        for (int i = 0; i < TAPS; i++) wr(i, i + 1);
        commit();
        clear_logs();
        send(1);
        for (int i = 0; i < TAPS; i++) send(0);
        wait_idle();
        chk("impulse_count", log0.size(), TAPS + 1);
        for (int i = 0; i < TAPS + 1; i++) chk("impulse", log0[i], (i < TAPS) ? i + 1 : 0);

        // full-scale saturation through the SHIFT=8 instance
        for (int i = 0; i < TAPS; i++) wr(i, 32767);
        commit();
        clear_logs();
        for (int i = 0; i < TAPS; i++) send(32767);
        wait_idle();
        chk("sat_count", log1.size(), TAPS);
        chk("sat_dout21", log1[TAPS-1], OMAX);
        chk("sat_flag21", logs1[TAPS-1], 1);

        // rounding with only tap 0 non-zero
        wr(0, 1);
        for (int i = 1; i < TAPS; i++) wr(i, 0);
        commit();
        clear_logs();
        send(128);
        send(127);
        send(-128);
        wait_idle();
        chk("round_128", log1[0], 1);
        chk("round_127", log1[1], 0);
        chk("round_m128", log1[2], 0);

        // commit during MAC is deferred to the next sample
        clear_logs();
        send(100);
        wr(0, 5);
        commit();
        send(50);
        wait_idle();
        chk("defer_old", log0[0], 100);
        chk("defer_new", log0[1], 250);

        // write, commit and acceptance on one edge
        clear_logs();
        coef_wr = 1'b1; coef_addr = 5'd1; coef_data = 16'd3;
        coef_commit = 1'b1; din = 16'd10; din_valid = 1'b1;
        tick();
        coef_wr = 1'b0; coef_commit = 1'b0; din_valid = 1'b0;
        wait_idle();
        chk("same_edge", log0[0], 200);

        // continuous din_valid
        dut_acc.delete();
        dv_log.delete();
        din_valid = 1'b1;
        repeat (4 * LAT + 2) begin
            din = 16'(rnd_val());
            tick();
        end
        din_valid = 1'b0;
        wait_idle();
        chk("bp_accepts", longint'(dut_acc.size() >= 4), 1);
        for (int i = 1; i < 4; i++) chk("bp_interval", dut_acc[i] - dut_acc[i-1], LAT);
        for (int i = 0; i < 4; i++) chk("bp_latency", dv_log[i] - dut_acc[i], LAT);

        // reset in the middle of MAC
        send(1234);
        repeat (9) tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", din_ready0, 1);
        chk("mid_rst_dout", dout0, 0);
        chk("mid_rst_valid", dout_valid0, 0);
        n = dv_log.size();
        tick();
        repeat (40) tick();
        chk("mid_rst_no_out", dv_log.size(), n);

        // random coefficients, samples and commits, some landing mid-computation
        for (int it = 0; it < 40; it++) begin
            int nw = int'($urandom_range(0, 3));
            for (int j = 0; j < nw; j++) wr(int'($urandom_range(0, 31)), rnd_val());
            if ($urandom_range(0, 1) == 1) commit();
            send(rnd_val());
            if ($urandom_range(0, 2) == 0) begin
                wr(int'($urandom_range(0, TAPS - 1)), rnd_val());
                commit();
            end
            coef_addr = 5'($urandom_range(0, 31));
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
